// File: rtl/timer_kick_master.sv
// timer_kick_master: Avalon-MM initiator that starts, kicks and services the watchdog timer.
// TIMER_KICK_MASTER_STATUS_LOG_EN adds status_last and skips the clear when the captured timeout bit is 0.
module timer_kick_master #(
  parameter int          KICK_INTERVAL = 400,
  parameter logic [15:0] CTRL_WORD     = 16'h0005,
  parameter int          CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kick_en,
  input  logic             irq,
  output logic [2:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic             m_read_n,
  output logic [15:0]      m_writedata,
  input  logic [15:0]      m_readdata,
  output logic             busy,
  output logic             timeout_pulse,
`ifdef TIMER_KICK_MASTER_STATUS_LOG_EN
  output logic [1:0]       status_last,
`endif
  output logic [CNT_W-1:0] timeout_count
);
  localparam int KW = $clog2(KICK_INTERVAL + 1);
  localparam logic [KW-1:0] RELOAD = KW'(KICK_INTERVAL - 1);
  typedef enum logic [2:0] {IDLE, CFG, RUN, KICK, RD_STAT, RD_WAIT, CLR} state_t;
  state_t state, nxt;
  logic [KW-1:0] cnt;
  logic clr_go;
  logic unused_rd;
  assign unused_rd = ^m_readdata;
`ifdef TIMER_KICK_MASTER_STATUS_LOG_EN
  assign clr_go = m_readdata[0];
`else
  assign clr_go = 1'b1;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CFG : IDLE;
      CFG:     nxt = RUN;
      KICK:    nxt = RUN;
      RUN:     nxt = irq ? RD_STAT : (cnt == '0 && kick_en) ? KICK : RUN;
      RD_STAT: nxt = RD_WAIT;
      RD_WAIT: nxt = clr_go ? CLR : RUN;
      CLR:     nxt = RUN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      m_address     <= '0;
      m_chipselect  <= 1'b0;
      m_write_n     <= 1'b1;
      m_read_n      <= 1'b1;
      m_writedata   <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
`ifdef TIMER_KICK_MASTER_STATUS_LOG_EN
      status_last   <= 2'b00;
`endif
    end else begin
      state         <= nxt;
      m_chipselect  <= nxt inside {CFG, KICK, RD_STAT, CLR};
      m_write_n     <= !(nxt inside {CFG, KICK, CLR});
      m_read_n      <= nxt != RD_STAT;
      m_address     <= nxt == CFG ? 3'd1 : nxt == KICK ? 3'd2 : 3'd0;
      m_writedata   <= nxt == CFG ? CTRL_WORD : 16'h0000;
      busy          <= nxt != IDLE;
      timeout_pulse <= state == CLR;
      if (state == CLR && timeout_count != '1)
        timeout_count <= timeout_count + CNT_W'(1);
      // a kick that fell due during irq service stays pending through CLR
      cnt <= (state == CFG || state == KICK) ? RELOAD :
             state == CLR ? (cnt == '0 ? '0 : RELOAD) :
             (state == RUN && !irq && cnt != '0) ? cnt - KW'(1) : cnt;
`ifdef TIMER_KICK_MASTER_STATUS_LOG_EN
      if (state == RD_WAIT)
        status_last <= m_readdata[1:0];
`endif
    end
  end
endmodule

// File: tb/tb_timer_kick_master.sv
// tb_timer_kick_master: directed bench with a behavioural timer slave and a bus-transaction scoreboard.
module tb_timer_kick_master;
  logic clk = 0, reset = 1, start = 0, kick_en = 0, trig = 0, spur = 0;
  logic irq;
  logic [2:0] m_address;
  logic m_chipselect, m_write_n, m_read_n;
  logic [15:0] m_writedata, m_readdata;
  logic busy, timeout_pulse;
  logic [7:0] timeout_count;
`ifdef TIMER_KICK_MASTER_STATUS_LOG_EN
  logic [1:0] status_last;
`endif
  logic t_run, t_to, t_ito;
  logic [8:0] tcnt;
  logic [15:0] rdata;
  int cyc = 0, errors = 0, checks = 0;
  bit sb_on = 0;
  logic [20:0] sb[$];

  timer_kick_master #(.KICK_INTERVAL(400), .CTRL_WORD(16'h0005), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .kick_en(kick_en), .irq(irq),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_read_n(m_read_n), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .busy(busy), .timeout_pulse(timeout_pulse),
`ifdef TIMER_KICK_MASTER_STATUS_LOG_EN
    .status_last(status_last),
`endif
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // timer slave: 500-cycle period, reload on addr 2 write, timeout cleared by addr 0 write
  assign irq = (t_to & t_ito) | spur;
  assign m_readdata = rdata;
  always @(posedge clk) begin
    if (reset) begin
      t_run <= 0; t_to <= 0; t_ito <= 0; tcnt <= 0; rdata <= 0;
    end else begin
      if (m_chipselect && !m_write_n && m_address == 3'd1) begin
        t_ito <= m_writedata[0]; t_run <= m_writedata[2]; tcnt <= 9'd499;
      end else if (m_chipselect && !m_write_n && m_address == 3'd2) tcnt <= 9'd499;
      else if (t_run) tcnt <= tcnt == 0 ? 9'd499 : tcnt - 9'd1;
      if ((t_run && tcnt == 0) || trig) t_to <= 1;
      else if (m_chipselect && !m_write_n && m_address == 3'd0) t_to <= 0;
      if (m_chipselect && !m_read_n) rdata <= {14'b0, t_run, t_to};
    end
  end

  function automatic logic [20:0] tx(input logic [2:0] a, input logic wr, input logic [15:0] d);
    return {a, !wr, wr, wr ? d : 16'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [20:0] exp;
    forever begin
      @(negedge clk);
      if (sb_on && m_chipselect) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_tx: observed addr %0h write_n %0b read_n %0b, expected no access",
                 m_address, m_write_n, m_read_n);
        end
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          chk("bus_tx", {11'b0, m_address, m_write_n, m_read_n, m_write_n ? 16'h0 : m_writedata}, {11'b0, exp});
        end
      end
    end
  endtask

  task automatic wait_tx(input string tag, input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget && c < 0; i++) begin
      @(negedge clk);
      if (m_chipselect) c = cyc;
    end
    if (c < 0) chk({tag, "_timeout"}, {31'b0, m_chipselect}, 1);
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (timeout_pulse) seen = 1;
    end
    chk(tag, {31'b0, seen}, 1);
  endtask

  initial begin
    int cfg_c, k1, k2, r, w, k;
    bit seen;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("rst_cs", m_chipselect, 0);
    chk("rst_write_n", m_write_n, 1);
    chk("rst_read_n", m_read_n, 1);
    chk("rst_addr", m_address, 0);
    chk("rst_wdata", m_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", timeout_pulse, 0);
    chk("rst_count", timeout_count, 0);
`ifdef TIMER_KICK_MASTER_STATUS_LOG_EN
    chk("rst_status", status_last, 0);
`endif
    reset = 0; kick_en = 1; sb_on = 1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    // configuration write one cycle after start
    sb.push_back(tx(3'd1, 1, 16'h0005));
    start = 1;
    @(negedge clk);
    start = 0; cfg_c = cyc;
    chk("cfg_busy", busy, 1);
    chk("cfg_addr", m_address, 1);
    chk("cfg_write_n", m_write_n, 0);
    chk("cfg_wdata", m_writedata, 16'h0005);
    // start outside IDLE must not reconfigure
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("run_busy", busy, 1);
    // periodic kicks every 401 cycles
    sb.push_back(tx(3'd2, 1, 16'h0));
    sb.push_back(tx(3'd2, 1, 16'h0));
    wait_tx("kick1", 500, k1);
    chk("kick1_gap", k1 - cfg_c, 401);
    wait_tx("kick2", 500, k2);
    chk("kick2_gap", k2 - k1, 401);
    chk("kick_no_irq", irq, 0);
    // kicks off: timer expires and is serviced
    kick_en = 0;
    sb.push_back(tx(3'd0, 0, 16'h0));
    sb.push_back(tx(3'd0, 1, 16'h0));
    wait_tx("svc_read", 700, r);
    chk("svc_irq_high", irq, 1);
    wait_tx("svc_clr", 5, w);
    chk("svc_clr_gap", w - r, 2);
    @(negedge clk);
    chk("svc_pulse", timeout_pulse, 1);
    chk("svc_count", timeout_count, 1);
    chk("svc_irq_low", irq, 0);
    @(negedge clk);
    chk("svc_pulse_once", timeout_pulse, 0);
    // irq and due kick together: service first, kick right after
    trig = 1;
    sb.push_back(tx(3'd0, 0, 16'h0));
    sb.push_back(tx(3'd0, 1, 16'h0));
    sb.push_back(tx(3'd2, 1, 16'h0));
    @(negedge clk);
    trig = 0; kick_en = 1;
    wait_tx("both_read", 5, r);
    wait_tx("both_clr", 5, w);
    chk("both_clr_gap", w - r, 2);
    wait_tx("both_kick", 5, k);
    chk("both_kick_gap", k - w, 2);
    chk("both_count", timeout_count, 2);
    // saturation of the timeout counter
    sb_on = 0; sb.delete();
    for (int i = 0; i < 300; i++) begin
      trig = 1;
      @(negedge clk);
      trig = 0;
      wait_pulse("sat_pulse", 20);
      if (i == 0) chk("sat_first", timeout_count, 3);
    end
    chk("sat_count", timeout_count, 255);
    // reset during RD_WAIT
    trig = 1;
    @(negedge clk);
    trig = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_chipselect && !m_read_n) seen = 1;
    end
    chk("rw_read_seen", {31'b0, seen}, 1);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rw_cs", m_chipselect, 0);
    chk("rw_busy", busy, 0);
    chk("rw_count", timeout_count, 0);
    reset = 0; sb.delete(); sb_on = 1;
    @(negedge clk);
    chk("rw_idle", busy, 0);
    // restart and raise an irq whose status shows no timeout
    sb.push_back(tx(3'd1, 1, 16'h0005));
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    spur = 1;
    sb.push_back(tx(3'd0, 0, 16'h0));
`ifndef TIMER_KICK_MASTER_STATUS_LOG_EN
    sb.push_back(tx(3'd0, 1, 16'h0));
`endif
    wait_tx("spur_read", 5, r);
    spur = 0;
`ifdef TIMER_KICK_MASTER_STATUS_LOG_EN
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (timeout_pulse) seen = 1;
    end
    chk("spur_no_pulse", {31'b0, seen}, 0);
    chk("spur_status", status_last, 2'b10);
    chk("spur_count", timeout_count, 0);
`else
    wait_tx("spur_clr", 5, w);
    chk("spur_clr_gap", w - r, 2);
    @(negedge clk);
    chk("spur_pulse", timeout_pulse, 1);
    chk("spur_count", timeout_count, 1);
`endif
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
